// File: rtl/axis_vec_driver.sv
// Stream driver/capture engine for axis_dot accelerators: sends a host-loaded
// vector on TX, collects the response on RX, and reports cycles, TLAST errors and timeouts.
module axis_vec_driver #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int IN_LEN      = 4,
  parameter  int OUT_LEN     = 4,
  parameter  int CYCLE_WIDTH = 32,
  parameter  int MAX_CYCLES  = 44100,
  localparam int IAW = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1,
  localparam int OAW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1,
  localparam int ICW = $clog2(IN_LEN)  + 1,
  localparam int OCW = $clog2(OUT_LEN) + 1
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IAW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   start,
  input  logic [OAW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err_last,
  output logic                   timeout,
  output logic [CYCLE_WIDTH-1:0] cycles,
  output logic [DATA_WIDTH-1:0]  TX_AXIS_TDATA,
  output logic                   TX_AXIS_TLAST,
  output logic                   TX_AXIS_TVALID,
  input  logic                   TX_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]  RX_AXIS_TDATA,
  input  logic                   RX_AXIS_TLAST,
  input  logic                   RX_AXIS_TVALID,
  output logic                   RX_AXIS_TREADY
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  inbuf  [IN_LEN];
  logic [DATA_WIDTH-1:0]  outbuf [OUT_LEN];
  logic [ICW-1:0]         tx_idx_q, tx_idx_d;
  logic [IAW-1:0]         tx_nidx;
  logic [OCW-1:0]         rx_idx_q;
  logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;
  logic [DATA_WIDTH-1:0]  tdata_q, rd_data_q;
  logic                   tvalid_q, tlast_q, rready_q, err_q, tmo_q;
  logic                   busy_w, tx_hs, rx_hs, rx_fin, rx_done;

  assign busy_w   = (state_q == SEND) || (state_q == RECV);
  assign tx_hs    = tvalid_q & TX_AXIS_TREADY;
  assign rx_hs    = rready_q & RX_AXIS_TVALID;
  assign rx_fin   = rx_hs && (rx_idx_q == OCW'(OUT_LEN - 1));
  assign rx_done  = (rx_idx_q == OCW'(OUT_LEN)) || rx_fin;
  assign tx_idx_d = tx_idx_q + ICW'(1);
  assign tx_nidx  = tx_idx_d[IAW-1:0];
  assign cycles_d = cycles_q + CYCLE_WIDTH'(1);

  // Buffer RAMs are never cleared; inbuf is frozen while a run is active.
  always_ff @(posedge aclk) begin
    if (wr_en && !busy_w) inbuf[wr_addr] <= wr_data;
    if (rx_hs && !rst)    outbuf[rx_idx_q[OAW-1:0]] <= RX_AXIS_TDATA;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_idx_q  <= '0;
      rx_idx_q  <= '0;
      cycles_q  <= '0;
      tdata_q   <= '0;
      rd_data_q <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      rd_data_q <= outbuf[rd_addr];
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= SEND;
            tx_idx_q <= '0;
            rx_idx_q <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            tvalid_q <= 1'b1;
            tdata_q  <= inbuf[0];
            tlast_q  <= (IN_LEN == 1);
            rready_q <= 1'b1;
          end
        end
        default: begin
          cycles_q <= cycles_d;
          if (rx_hs) begin
            rx_idx_q <= rx_idx_q + OCW'(1);
            // TLAST must be present exactly on the final expected beat.
            if (RX_AXIS_TLAST != rx_fin) err_q <= 1'b1;
            if (rx_fin) rready_q <= 1'b0;
          end
          if (tx_hs) begin
            tx_idx_q <= tx_idx_d;
            if (tlast_q) begin
              tvalid_q <= 1'b0;
            end else begin
              tdata_q <= inbuf[tx_nidx];
              tlast_q <= (tx_idx_d == ICW'(IN_LEN - 1));
            end
          end
          if (tx_hs && tlast_q) begin
            state_q <= rx_done ? DONE : RECV;
          end else if (state_q == RECV && rx_fin) begin
            state_q <= DONE;
          end else if (cycles_d == CYCLE_WIDTH'(MAX_CYCLES)) begin
            tmo_q    <= 1'b1;
            tvalid_q <= 1'b0;
            rready_q <= 1'b0;
            state_q  <= DONE;
          end
        end
      endcase
    end
  end

  assign rd_data        = rd_data_q;
  assign busy           = busy_w;
  assign done           = (state_q == DONE);
  assign err_last       = err_q;
  assign timeout        = tmo_q;
  assign cycles         = cycles_q;
  assign TX_AXIS_TDATA  = tdata_q;
  assign TX_AXIS_TLAST  = tlast_q;
  assign TX_AXIS_TVALID = tvalid_q;
  assign RX_AXIS_TREADY = rready_q;

endmodule

// File: tb/tb_axis_vec_driver.sv
// Scoreboard bench for axis_vec_driver: TX words checked in order, RX words
// read back from the result buffer, plus flag/cycle/timeout/reset checks.
module tb_axis_vec_driver;

  logic        aclk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [1:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data, cycles, tx_tdata;
  logic        busy, done, err_last, timeout, tx_tlast, tx_tvalid, rx_tready;
  logic        tx_tready = 1'b0, rx_tlast = 1'b0, rx_tvalid = 1'b0;
  logic [31:0] rx_tdata = '0;

  int errs = 0, checks = 0;
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [31:0] vin  [4] = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD};
  logic [31:0] vout [4] = '{32'h40733334, 32'h408CCCCD, 32'h40A00000, 32'h40B33334};

  always #5 aclk = ~aclk;

  axis_vec_driver dut (
    .aclk(aclk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .err_last(err_last), .timeout(timeout), .cycles(cycles),
    .TX_AXIS_TDATA(tx_tdata), .TX_AXIS_TLAST(tx_tlast), .TX_AXIS_TVALID(tx_tvalid),
    .TX_AXIS_TREADY(tx_tready), .RX_AXIS_TDATA(rx_tdata), .RX_AXIS_TLAST(rx_tlast),
    .RX_AXIS_TVALID(rx_tvalid), .RX_AXIS_TREADY(rx_tready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic load();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = vin[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // One run: txmode 1 toggles TREADY, rxgap idles RX between beats, lastpos
  // is the RX beat carrying TLAST, poke drives start/wr_en while busy.
  task automatic run(input int txmode, input int rxgap, input int lastpos,
                     input bit rx_silent, input bit poke, input int budget,
                     output int lastk);
    int k = 0, txn = 0, rxn = 0, gap = 0;
    bit hold = 1'b0;
    logic [31:0] held = '0;
    lastk = -1;
    for (int i = 0; i < 4; i++) txq.push_back(vin[i]);
    start = 1'b1; tick(); start = 1'b0;
    while (!done && k < budget) begin
      start   = poke && (k == 1);
      wr_en   = poke && (k == 5);
      wr_addr = '0; wr_data = 32'hDEADBEEF;
      if (poke && k == 5) chk("poke_busy", busy, 1);
      tx_tready = (txmode == 0) || (k % 2 == 0);
      if (hold) chk("tx_stable", tx_tdata, held);
      hold = tx_tvalid && !tx_tready;
      held = tx_tdata;
      if (tx_tvalid && tx_tready) begin
        if (txq.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_data", tx_tdata, txq.pop_front());
        chk("tx_last", tx_tlast, txn == 3);
        txn++; lastk = k;
      end
      rx_tvalid = !rx_silent && rxn < 4 && gap == 0;
      if (rx_tvalid) begin
        rx_tdata = vout[rxn]; rx_tlast = (rxn == lastpos);
      end else rx_tlast = 1'b0;
      if (rx_tvalid && rx_tready) begin
        rxq.push_back(vout[rxn]); rxn++; gap = rxgap; lastk = k;
      end else if (gap > 0) gap--;
      tick(); k++;
    end
    start = 1'b0; wr_en = 1'b0; tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0;
    chk("done", done, 1);
    chk("tx_left", txq.size(), 0);
    chk("txvalid_off", tx_tvalid, 0);
    chk("rxready_off", rx_tready, 0);
    chk("busy_off", busy, 0);
    txq.delete();
  endtask

  task automatic readback();
    int n = rxq.size();
    for (int i = 0; i < n; i++) begin
      rd_addr = 2'(i); tick();
      chk("rd_data", rd_data, rxq.pop_front());
    end
  endtask

  initial begin
    int lk, c1;
    rst = 1'b1; tick(); tick();
    chk("rst_txvalid", tx_tvalid, 0); chk("rst_rxready", rx_tready, 0);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_cycles", cycles, 0);     chk("rst_err", err_last, 0);
    chk("rst_tmo", timeout, 0);       chk("rst_rd", rd_data, 0);
    rst = 1'b0;
    load();

    // basic run, loopback answers immediately
    run(0, 0, 3, 1'b0, 1'b0, 100, lk);
    chk("s1_cycles", cycles, 4); chk("s1_cyc_model", cycles, lk + 1);
    chk("s1_err", err_last, 0);  chk("s1_tmo", timeout, 0);
    c1 = cycles;
    readback();
    chk("s1_done_hold", done, 1);

    // TX backpressure and RX gaps
    run(1, 3, 3, 1'b0, 1'b0, 200, lk);
    chk("s2_cyc_model", cycles, lk + 1);
    chk("s2_stalls", cycles - c1, 9);
    chk("s2_err", err_last, 0);
    readback();

    // early TLAST
    run(0, 0, 1, 1'b0, 1'b0, 100, lk);
    chk("s3_err", err_last, 1); chk("s3_cycles", cycles, lk + 1);
    readback();

    // silent sink -> timeout
    run(0, 0, 3, 1'b1, 1'b0, 44200, lk);
    chk("s4_tmo", timeout, 1); chk("s4_cycles", cycles, 44100);
    chk("s4_err", err_last, 0);

    // reset after two TX beats
    start = 1'b1; tick(); start = 1'b0; tx_tready = 1'b1;
    chk("s5_w0", tx_tdata, vin[0]); tick();
    chk("s5_w1", tx_tdata, vin[1]); tick();
    rst = 1'b1; tick();
    chk("s5_txvalid", tx_tvalid, 0); chk("s5_busy", busy, 0);
    chk("s5_cycles", cycles, 0);     chk("s5_done", done, 0);
    chk("s5_rxready", rx_tready, 0); chk("s5_tmo", timeout, 0);
    rst = 1'b0; tx_tready = 1'b0;
    run(0, 0, 3, 1'b0, 1'b0, 100, lk);
    chk("s5_cycles_rerun", cycles, 4);
    readback();

    // start/wr_en while busy are ignored; rerun clears flags
    run(0, 3, 1, 1'b0, 1'b1, 200, lk);
    chk("s6_err", err_last, 1); chk("s6_cyc_model", cycles, lk + 1);
    readback();
    run(0, 0, 3, 1'b0, 1'b0, 100, lk);
    chk("s6_err_clr", err_last, 0); chk("s6_tmo_clr", timeout, 0);
    chk("s6_cycles", cycles, 4);
    readback();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
